reflet_uart_loader: RTL



---
 rtl/reflet_loader_pkg.sv | 29 ++
 rtl/reflet_loader_rx.sv | 91 +++++++++
 rtl/reflet_uart_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reflet_loader_pkg.sv
// Shared types and derived timing for the UART program loader.
package reflet_loader_pkg;

  typedef enum logic [2:0] {
    BOOT, WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, RUN
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  // Start + 8 data + stop: one byte time on the wire, in bit periods.
  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_period(input int unsigned bp);
    return bp / 2;
  endfunction

  function automatic int unsigned gap_cycles(input int unsigned gap_timeout,
                                             input int unsigned bp);
    return gap_timeout * FRAME_BITS * bp;
  endfunction

endpackage

// File: rtl/reflet_loader_rx.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampling, one-cycle byte/error pulses.
module reflet_loader_rx #(
  parameter int unsigned BIT_PERIOD  = 104,
  parameter int unsigned HALF_PERIOD = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  import reflet_loader_pkg::*;

  localparam int CW = $clog2(BIT_PERIOD + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

  rx_state_t     state, state_nxt;
  logic [2:0]    sync_q;      // [1:0] synchroniser, [2] previous synced level
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          rx_s, rx_prev, tick_half, tick_bit;

  assign rx_s      = sync_q[1];
  assign rx_prev   = sync_q[2];
  assign tick_half = (cnt == HALF_LAST);
  assign tick_bit  = (cnt == BIT_LAST);
  assign byte_data = shift_q;

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RX_IDLE;
    else        state <= state_nxt;

  // Next state; a start needs a falling edge so a low stop bit cannot retrigger.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rx_s && rx_prev)          state_nxt = RX_START;
      RX_START: if (tick_half)                 state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_bit && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (tick_bit)                  state_nxt = RX_IDLE;
      default:                                 state_nxt = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 3'b111;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= tick_half ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (tick_bit) begin
            cnt     <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_bit) begin
            cnt <= '0;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/reflet_uart_loader.sv
// Boot loader: receives a length/data/checksum frame over UART, writes it to
// instruction RAM and holds the CPU in reset until a frame verifies.
module reflet_uart_loader #(
  parameter int unsigned clk_freq    = 1000000,
  parameter int unsigned baud_rate   = 9600,
  parameter int unsigned addr_size   = 7,
  parameter logic [7:0]  sync_byte   = 8'hA5,
  parameter int unsigned boot_window = 100000,
  parameter int unsigned gap_timeout = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [addr_size-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_reset,
  output logic                 loading,
  output logic                 error
);
  import reflet_loader_pkg::*;

  localparam int unsigned BIT_PERIOD  = bit_period(clk_freq, baud_rate);
  localparam int unsigned HALF_PERIOD = half_period(BIT_PERIOD);
  localparam int unsigned GAP_CYCLES  = gap_cycles(gap_timeout, BIT_PERIOD);
  localparam int unsigned IMG_BYTES   = 1 << addr_size;
  localparam int BCW = $clog2(boot_window + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [addr_size:0] LEN_MAX = (addr_size + 1)'(IMG_BYTES);
  localparam logic [addr_size:0] LEN_ONE = (addr_size + 1)'(1);

  load_state_t          state, state_nxt;
  logic                 byte_valid, frame_err;
  logic [7:0]           byte_data, sum_q, sum_chk;
  logic [addr_size:0]   len_q, len_d, wr_cnt;
  logic [BCW-1:0]       boot_cnt;
  logic [GCW-1:0]       gap_cnt;
  logic                 is_sync, boot_done, gap_hit, abort;

  reflet_loader_rx #(
    .BIT_PERIOD (BIT_PERIOD),
    .HALF_PERIOD(HALF_PERIOD)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign loading   = (state == GET_LEN) || (state == GET_DATA) || (state == GET_SUM);
  assign is_sync   = byte_valid && (byte_data == sync_byte);
  assign boot_done = (boot_cnt == BCW'(boot_window - 1));
  assign gap_hit   = (gap_cnt == GCW'(GAP_CYCLES - 1));
  assign abort     = loading && (frame_err || gap_hit);
  assign sum_chk   = sum_q + byte_data;
  // Length 0 means a full image; anything larger than the RAM is clamped.
  assign len_d     = (byte_data == 8'd0 || 32'(byte_data) > IMG_BYTES)
                   ? LEN_MAX : (addr_size + 1)'(byte_data);

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= BOOT;
    else        state <= state_nxt;

  // Next-state logic; a framing error or idle gap aborts any frame in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: begin
        if (is_sync)        state_nxt = GET_LEN;
        else if (boot_done) state_nxt = RUN;
      end
      WAIT_SYNC: if (is_sync)    state_nxt = GET_LEN;
      GET_LEN:   if (byte_valid) state_nxt = GET_DATA;
      GET_DATA:  if (mem_write_en && wr_cnt == len_q - LEN_ONE) state_nxt = GET_SUM;
      GET_SUM:   if (byte_valid) state_nxt = (sum_chk == 8'd0) ? RUN : WAIT_SYNC;
      RUN:       if (is_sync)    state_nxt = GET_LEN;
      default:                   state_nxt = BOOT;
    endcase
    if (abort) state_nxt = WAIT_SYNC;
  end

  // Datapath: write strobe, address/checksum update on the strobe cycle, timers, flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      cpu_reset    <= 1'b0;
      error        <= 1'b0;
      sum_q        <= '0;
      len_q        <= '0;
      wr_cnt       <= '0;
      boot_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      mem_write_en <= 1'b0;
      // Released only once RUN has been held for a full cycle; drops as RUN is left.
      cpu_reset    <= (state == RUN) && (state_nxt == RUN);
      gap_cnt      <= (byte_valid || !loading) ? '0 : gap_cnt + 1'b1;
      if (state == BOOT && !boot_done) boot_cnt <= boot_cnt + 1'b1;
      case (state)
        GET_LEN: if (byte_valid) begin
          mem_addr <= '0;
          sum_q    <= byte_data;
          len_q    <= len_d;
          wr_cnt   <= '0;
        end
        GET_DATA: begin
          if (byte_valid) begin
            mem_data     <= byte_data;
            mem_write_en <= 1'b1;
          end
          if (mem_write_en) begin
            mem_addr <= mem_addr + 1'b1;
            sum_q    <= sum_q + mem_data;
            wr_cnt   <= wr_cnt + 1'b1;
          end
        end
        GET_SUM: if (byte_valid) error <= (sum_chk != 8'd0);
        default: ;
      endcase
      if (abort) error <= 1'b1;
    end
  end

endmodule
